// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
//
// Read-side adapter for the team SyncFIFO. It pops words through the FIFO
// read port (rden/rddata/empty) and presents them as a valid/ready stream
// with packet framing. A 2-entry skid buffer (head + spare) hides the FIFO's
// one-cycle read latency. This lets the block move one word per cycle under
// continuous m_ready and hold data steady under backpressure.
//
// Parameters:
//   WIDTH    data width, must match the FIFO WIDTH
//   PKT_LEN  words per packet (>= 1); sets where m_last falls
//   CNT_W    width of rd_cnt (only meaningful with FIFO_RD_CNT_EN)
//
// Ports:
//   clk        system clock, rising edge
//   sys_rst_n  synchronous active-low reset
//   rden       FIFO read strobe (combinational)
//   rddata     FIFO read data, valid the cycle after rden
//   empty      FIFO empty flag
//   m_valid    output word valid
//   m_data     output word
//   m_last     final word of a packet, qualified by m_valid
//   m_ready    downstream accept
//   rd_cnt     accepted-word counter (only when FIFO_RD_CNT_EN is defined)
//
// Build option:
//   FIFO_RD_CNT_EN  when defined, adds the rd_cnt port and its counter.

module fifo_rd_stream #(
  parameter int WIDTH   = 4,
  parameter int PKT_LEN = 5,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             sys_rst_n,
  output logic             rden,
  input  logic [WIDTH-1:0] rddata,
  input  logic             empty,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  input  logic             m_ready
`ifdef FIFO_RD_CNT_EN
  ,
  output logic [CNT_W-1:0] rd_cnt
`endif
);

  localparam int PW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(PKT_LEN - 1);

  if (PKT_LEN < 1 || CNT_W < 1) begin : g_bad_cfg
    $error("fifo_rd_stream: PKT_LEN and CNT_W must both be at least 1");
  end

  logic [1:0]       occ;
  logic [1:0]       occ_nxt;
  logic             inflight;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] head_nxt;
  logic [WIDTH-1:0] spare;
  logic [WIDTH-1:0] spare_nxt;
  logic [PW-1:0]    pkt_cnt;
  logic             pop;
  logic [2:0]       committed;

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid & m_ready;
  assign m_data  = head;
  assign m_last  = m_valid & (pkt_cnt == LAST_IDX);

  // Slots that will still be occupied or claimed after this cycle. A pop
  // frees a slot in the same cycle, so a read can be issued into it. That is
  // why m_ready feeds rden combinationally. pop implies occ >= 1, so this
  // never underflows.
  assign committed = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign rden      = sys_rst_n & ~empty & (committed < 3'd2);

  // Skid buffer update. A word arriving from the FIFO goes to the head when
  // the buffer is empty or the head is leaving this cycle. Otherwise it
  // goes to the spare slot. On a pop, the spare moves up to the head.
  always_comb begin
    head_nxt  = head;
    spare_nxt = spare;
    occ_nxt   = occ;
    case ({inflight, pop})
      2'b11: begin
        if (occ == 2'd2) begin
          head_nxt  = spare;
          spare_nxt = rddata;
        end else begin
          head_nxt = rddata;
        end
      end
      2'b01: begin
        if (occ == 2'd2) begin
          head_nxt = spare;
        end
        occ_nxt = occ - 2'd1;
      end
      2'b10: begin
        if (occ == 2'd0) begin
          head_nxt = rddata;
        end else begin
          spare_nxt = rddata;
        end
        occ_nxt = occ + 2'd1;
      end
      default: ;
    endcase
  end

  // Buffer, read tracking and packet position. Reset drops every buffered
  // or in-flight word; words still held in the FIFO are not affected.
  always_ff @(posedge clk) begin
    if (!sys_rst_n) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      head     <= '0;
      spare    <= '0;
      pkt_cnt  <= '0;
    end else begin
      occ      <= occ_nxt;
      inflight <= rden;
      head     <= head_nxt;
      spare    <= spare_nxt;
      if (pop) begin
        pkt_cnt <= (pkt_cnt == LAST_IDX) ? '0 : pkt_cnt + 1'b1;
      end
    end
  end

`ifdef FIFO_RD_CNT_EN
  // Free-running count of accepted words; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!sys_rst_n) begin
      rd_cnt <= '0;
    end else if (pop) begin
      rd_cnt <= rd_cnt + 1'b1;
    end
  end
`else
  // No accepted-word counter in this build.
`endif

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side adapter for the team's synchronous FIFO. It pops words through the FIFO's `rden`/`rddata`/`empty` port and presents them as a registered valid/ready stream with packet framing. A 2-entry skid buffer hides the FIFO's 1-cycle read latency, so the block sustains one word per cycle under continuous `m_ready` and holds data stably under backpressure. It sits between a SyncFIFO instance and any downstream stream consumer.

## Interface
- `WIDTH`, default 4: data width in bits; must match the FIFO `WIDTH`.
- `PKT_LEN`, default 5: words per packet, ≥1; sets where `m_last` falls.
- `CNT_W`, default 16: width of `rd_cnt`. Used only with `FIFO_RD_CNT_EN`.

- `clk`  in  1  system clock. All logic is on the rising edge.
- `sys_rst_n`  in  1  reset. Synchronous and active-low.
- `rden`  out  1  FIFO read strobe.
- `rddata`  in  WIDTH  FIFO read data, valid in the cycle after `rden` was high.
- `empty`  in  1  FIFO empty flag.
- `m_valid`  out  1  output word valid.
- `m_data`  out  WIDTH  output word.
- `m_last`  out  1  marks the final word of a packet; qualified by `m_valid`.
- `m_ready`  in  1  downstream accept.
- `rd_cnt`  out  CNT_W  count of accepted words. Present only with `FIFO_RD_CNT_EN`.

## Operation
**Internal state**
- `occ`: words held in the buffer, 0..2. Head word drives `m_data`/`m_valid`.
- `inflight`: 1 when `rden` was issued last cycle.
- `pkt_cnt`: 0..PKT_LEN-1.

**Definitions**
- pop = `m_valid & m_ready`.
- `rden = sys_rst_n & ~empty & ((occ + inflight - pop) < 2)`.
  - Combinational path from `m_ready` to `rden` is intended.
  - Invariant: `occ + inflight ≤ 2` at all times.

**Word handling**
- `rden` is never asserted while `empty=1`, so the FIFO cannot underflow.
- When `inflight=1`, `rddata` is captured into the buffer at the end of that cycle.
- If the buffer is empty, or the head is being popped that same cycle, the captured word becomes the head. Otherwise it goes to the spare slot.
- On pop, the spare slot (if occupied) moves to the head.
- Order is strictly FIFO. No word is dropped or duplicated.
- `m_valid = (occ != 0)`.

**Output stability and framing**
- While `m_valid=1` and `m_ready=0`, `m_data` and `m_last` hold their values.
- `m_last = m_valid & (pkt_cnt == PKT_LEN-1)`.
- `pkt_cnt` increments on each pop and wraps to 0 after PKT_LEN-1.
- With `PKT_LEN=1`, every word has `m_last=1`.

**Reset**
- When `sys_rst_n=0` at a clock edge, the following clear on that edge: `occ`, `inflight`, `pkt_cnt`, the buffer, and `rd_cnt`.
- Any in-flight word and all buffered words are discarded. Words still in the FIFO are untouched.

## Timing
**Reset values**
- `rden` is 0 (combinationally gated by `sys_rst_n`).
- `m_valid=0`, `m_data=0`, `m_last=0`, `rd_cnt=0`.

**Latency**
- `rden` high in cycle N → `rddata` valid in N+1 → `m_valid` high in N+2.
- First word appears 2 cycles after `empty` falls, provided the buffer had room.

**Throughput**
- With `m_ready` held at 1 and the FIFO non-empty, `rden` and pop are both high every cycle in steady state: one word per cycle.

**Backpressure**
- With `m_ready=0`, at most 2 reads are issued before `rden` stays low.

**Simultaneous events**
- Capture and pop in the same cycle leave `occ` unchanged.
- `empty` rising while `inflight=1` is legal; the in-flight word is still captured.

**Reset mid-operation**
- The first cycle after release behaves as if from idle.

## Configuration
- Macro: `FIFO_RD_CNT_EN`.
- Defined: port `rd_cnt` exists. It increments by 1 on every pop, wraps modulo 2^CNT_W, and clears on reset.
- Undefined: port `rd_cnt` and its counter are absent. All other behaviour is identical.

## Test plan
Setup: FIFO with DEPTH=10, WIDTH=4; this block with PKT_LEN=5.

- **Reset:** hold `sys_rst_n=0` for 2 cycles while the FIFO is non-empty → `rden`, `m_valid`, `m_data`, `m_last` all stay 0.
- **Streaming:** write 0..9 into the FIFO, `m_ready=1` → `m_data` = 0..9 on 10 consecutive cycles, `m_last` on words 4 and 9, exactly 10 `rden` pulses, `rden` never high with `empty=1`.
- **Backpressure:** FIFO holds 0..9, `m_ready=0` → exactly 2 `rden` pulses, `m_data=0` held. Then release `m_ready` → words 0..9 in order with no gap after the first.
- **Toggling accept:** `m_ready` toggles every cycle while writing 0..9 concurrently → output is exactly 0..9, each word held until accepted, `m_last` on words 4 and 9.
- **Reset mid-stream:** assert reset after 3 pops → outputs are 0 the next cycle. After release, the next accepted word restarts framing: `m_last` lands on the 5th word after reset.
- **Counter:** with `FIFO_RD_CNT_EN` defined, `rd_cnt=10` after the streaming test and 0 after reset. Without the macro, the design elaborates with no `rd_cnt` port.
